// File: rtl/bcd7_pkg.sv
// Shared constants, payload type and segment lookup for the BCD7 display back-end.
package bcd7_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef enum logic {PH_BLANK = 1'b0, PH_ON = 1'b1} scan_phase_e;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } disp_payload_t;

  // Active-low {dp..a} pattern for one hex digit, dp segment off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern with dp and blank.
module hex_to_seg7
  import bcd7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    if (!blank_i) begin
      seg_c_o = hex_seg(nibble_i);
      if (dp_i) seg_c_o[7] = 1'b0;
    end
  end

endmodule

// File: rtl/bcd7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-aligned double
// buffering, per-slot anti-ghosting blank and optional leading-zero blanking.
module bcd7_scan_driver
  import bcd7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        data_valid,
  output logic [11:0] BCD7,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  disp_payload_t    pend_q, pend_d, act_q, act_d;
  logic             pend_flag_q, pend_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dsel_q, dsel_d;
  logic             frame_done_q, frame_done_d;
  logic [11:0]      bcd7_q, bcd7_d;

  scan_phase_e phase_c;
  logic [3:0]  nib_c;
  logic        dp_c;
  logic [3:0]  lz_c;
  logic [7:0]  seg_c;
  logic        slot_wrap_c;
  logic        boundary_c;

  // A zero-length blank window would make the comparison constant, so elide it.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign phase_c = PH_ON;
    end else begin : g_blank
      assign phase_c = (cnt_q < CNT_W'(BLANK_CYC)) ? PH_BLANK : PH_ON;
    end
  endgenerate

  assign nib_c = act_q.val[{dsel_q, 2'b00} +: 4];
  assign dp_c  = act_q.dp[dsel_q];

  // Digit i blanks when it and all higher nibbles are zero and its dp is off.
  always_comb begin
    lz_c = '0;
    if (BLANK_LZ != 0) begin
      lz_c[3] = (act_q.val[15:12] == 4'h0)  && !act_q.dp[3];
      lz_c[2] = (act_q.val[15:8]  == 8'h00) && !act_q.dp[2];
      lz_c[1] = (act_q.val[15:4]  == 12'h0) && !act_q.dp[1];
    end
  end

  hex_to_seg7 u_seg (
    .nibble_i (nib_c),
    .dp_i     (dp_c),
    .blank_i  (lz_c[dsel_q]),
    .seg_c_o  (seg_c)
  );

  assign slot_wrap_c = (cnt_q == CNT_LAST);
  assign boundary_c  = slot_wrap_c && (dsel_q == 2'd3);

  always_comb begin
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    act_d        = act_q;
    cnt_d        = slot_wrap_c ? '0 : cnt_q + CNT_W'(1);
    dsel_d       = slot_wrap_c ? dsel_q + 2'd1 : dsel_q;
    frame_done_d = boundary_c;
    bcd7_d       = {ANODE_OFF, SEG_BLANK};

    // A strobe coinciding with the boundary bypasses the pending buffer.
    if (boundary_c) begin
      pend_flag_d = 1'b0;
      if (data_valid) begin
        act_d = '{val: data_in, dp: dp_in};
      end else if (pend_flag_q) begin
        act_d = pend_q;
      end
    end else if (data_valid) begin
      pend_d      = '{val: data_in, dp: dp_in};
      pend_flag_d = 1'b1;
    end

    if (phase_c == PH_ON) begin
      bcd7_d = {~(4'b0001 << dsel_q), seg_c};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      act_q        <= '0;
      cnt_q        <= '0;
      dsel_q       <= 2'd0;
      frame_done_q <= 1'b0;
      bcd7_q       <= {ANODE_OFF, SEG_BLANK};
    end else begin
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      act_q        <= act_d;
      cnt_q        <= cnt_d;
      dsel_q       <= dsel_d;
      frame_done_q <= frame_done_d;
      bcd7_q       <= bcd7_d;
    end
  end

  assign BCD7       = bcd7_q;
  assign digit_sel  = dsel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd7_scan_driver.sv
// Directed plus randomized bench for bcd7_scan_driver against a cycle-position model.
module tb_bcd7_scan_driver;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_valid;
  logic [11:0] bcd7, bcd7_nolz;
  logic [1:0]  dsel, dsel_nolz;
  logic        fd, fd_nolz;

  always #5 clk = ~clk;

  bcd7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .data_valid(data_valid), .BCD7(bcd7), .digit_sel(dsel), .frame_done(fd)
  );

  bcd7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .data_valid(data_valid), .BCD7(bcd7_nolz), .digit_sel(dsel_nolz), .frame_done(fd_nolz)
  );

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release plus the two display buffers.
  int          n;
  logic [15:0] m_act_v, m_pend_v;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pend_f;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [11:0] exp_bcd7(input int pos, input logic [15:0] v,
                                           input logic [3:0] dp, input bit lz);
    int         dig;
    int         slot;
    logic [3:0] nib;
    logic [3:0] an;
    logic [7:0] seg;
    dig  = (pos / SD) % 4;
    slot = pos % SD;
    if (slot < BC) return 12'hFFF;
    nib = 4'(v >> (4 * dig));
    if (lz && dig > 0 && (v >> (4 * dig)) == 16'h0 && !dp[dig]) begin
      seg = 8'hFF;
    end else begin
      seg = seg_tab[nib];
      if (dp[dig]) seg = seg & 8'h7F;
    end
    an      = 4'hF;
    an[dig] = 1'b0;
    return {an, seg};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    n         = 0;
    m_act_v   = 16'h0;
    m_act_dp  = 4'h0;
    m_pend_v  = 16'h0;
    m_pend_dp = 4'h0;
    m_pend_f  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, check every output after the edge.
  task automatic tick(input bit v, input logic [15:0] d, input logic [3:0] p);
    int         pos;
    logic [11:0] e, e_nolz;
    logic [1:0]  e_dsel;
    bit          e_fd;
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    dp_in      = p;
    pos    = n % FRAME;
    e      = exp_bcd7(pos, m_act_v, m_act_dp, 1'b1);
    e_nolz = exp_bcd7(pos, m_act_v, m_act_dp, 1'b0);
    e_dsel = 2'(((n + 1) / SD) % 4);
    e_fd   = (pos == FRAME - 1);
    if (pos == FRAME - 1) begin
      if (v) begin
        m_act_v  = d;
        m_act_dp = p;
      end else if (m_pend_f) begin
        m_act_v  = m_pend_v;
        m_act_dp = m_pend_dp;
      end
      m_pend_f = 1'b0;
    end else if (v) begin
      m_pend_v  = d;
      m_pend_dp = p;
      m_pend_f  = 1'b1;
    end
    n++;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    chk("bcd7", 16'(bcd7), 16'(e));
    chk("bcd7_nolz", 16'(bcd7_nolz), 16'(e_nolz));
    chk("digit_sel", 16'(dsel), 16'(e_dsel));
    chk("digit_sel_nolz", 16'(dsel_nolz), 16'(e_dsel));
    chk("frame_done", 16'(fd), 16'(e_fd));
    chk("frame_done_nolz", 16'(fd_nolz), 16'(e_fd));
  endtask

  // Idle until the tick that sampled frame position pos (always at least one tick).
  task automatic idle_until(input int pos);
    do tick(1'b0, 16'h0, 4'h0); while (((n - 1) % FRAME) != pos);
  endtask

  initial begin
    int          pulses;
    bit          v;
    logic [15:0] d;
    logic [3:0]  p;

    reset      = 1'b1;
    data_in    = 16'h0;
    dp_in      = 4'h0;
    data_valid = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("reset_bcd7", 16'(bcd7), 16'hFFF);
    chk("reset_bcd7_nolz", 16'(bcd7_nolz), 16'hFFF);
    chk("reset_digit_sel", 16'(dsel), 16'h0);
    chk("reset_frame_done", 16'(fd), 16'h0);
    reset = 1'b0;

    // First ON phase after reset shows "0" on digit 0.
    idle_until(3);
    chk("s1_first_zero", 16'(bcd7), 16'hEC0);

    // Scenario 1: 12A8 appears in the next frame.
    tick(1'b1, 16'h12A8, 4'h0);
    idle_until(31);
    idle_until(2);
    chk("s1_d0", 16'(bcd7), 16'hE80);
    idle_until(10);
    chk("s1_d1", 16'(bcd7), 16'hD88);
    idle_until(18);
    chk("s1_d2", 16'(bcd7), 16'hBA4);
    idle_until(26);
    chk("s1_d3", 16'(bcd7), 16'h7F9);

    // Scenario 2: mid-frame strobe never tears the current frame.
    idle_until(10);
    tick(1'b1, 16'h0005, 4'h0);
    idle_until(26);
    chk("s2_old_d3", 16'(bcd7), 16'h7F9);
    idle_until(2);
    chk("s2_new_d0", 16'(bcd7), 16'hE92);
    idle_until(26);
    chk("s2_lz_d3", 16'(bcd7), 16'h7FF);
    pulses = 0;
    repeat (2 * FRAME) begin
      tick(1'b0, 16'h0, 4'h0);
      pulses += int'(fd);
    end
    chk("s2_fd_count", 16'(pulses), 16'd2);

    // Scenario 3: dp keeps a zero digit lit; LZ disabled shows every zero.
    tick(1'b1, 16'h0050, 4'b0100);
    idle_until(31);
    idle_until(18);
    chk("s3_d2_dp", 16'(bcd7), 16'hB40);
    idle_until(26);
    chk("s3_d3_lz", 16'(bcd7), 16'h7FF);
    chk("s3_d3_nolz", 16'(bcd7_nolz), 16'h7C0);

    // Scenario 4: last strobe within a frame wins.
    idle_until(5);
    tick(1'b1, 16'h1111, 4'h0);
    repeat (3) tick(1'b0, 16'h0, 4'h0);
    tick(1'b1, 16'h2222, 4'h0);
    idle_until(31);
    idle_until(10);
    chk("s4_last_wins", 16'(bcd7), 16'hDA4);
    repeat (FRAME) tick(1'b0, 16'h0, 4'h0);

    // Scenario 5: strobe in the boundary cycle bypasses straight to active.
    idle_until(30);
    tick(1'b1, 16'hFFFF, 4'h0);
    idle_until(2);
    chk("s5_bypass", 16'(bcd7), 16'hE8E);

    // Scenario 6: asynchronous reset while digit 2 is lit.
    tick(1'b1, 16'h0700, 4'h0);
    idle_until(31);
    idle_until(19);
    chk("s6_pre_d2", 16'(bcd7), 16'hBF8);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_bcd7", 16'(bcd7), 16'hFFF);
    chk("s6_async_digit_sel", 16'(dsel), 16'h0);
    chk("s6_async_frame_done", 16'(fd), 16'h0);
    @(posedge clk);
    #1;
    chk("s6_hold_bcd7", 16'(bcd7), 16'hFFF);
    reset = 1'b0;
    model_clear();
    idle_until(3);
    chk("s6_after_zero", 16'(bcd7), 16'hEC0);

    // Randomized traffic with leading-zero-heavy values and sparse dp.
    repeat (600) begin
      v = ($urandom_range(0, 11) == 0);
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick(v, d, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
